// File: rtl/tlk2711_dma_arb.sv
// Round-robin sharing of one tlk2711_dma engine between N_CH link channels.
// Read and write paths arbitrate independently; each grant covers one command plus its full data transfer.
module tlk2711_dma_arb #(
  parameter int N_CH        = 2,
  parameter int ADDR_WIDTH  = 48,
  parameter int DLEN_WIDTH  = 16,
  parameter int RDATA_WIDTH = 64,
  parameter int WDATA_WIDTH = 64,
  parameter int WBYTE_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_soft_rst,
  input  logic [N_CH-1:0]                      i_ch_en,
  input  logic [N_CH-1:0]                      i_ch_rd_cmd_req,
  input  logic [N_CH*(DLEN_WIDTH+ADDR_WIDTH)-1:0] i_ch_rd_cmd_data,
  output logic [N_CH-1:0]                      o_ch_rd_cmd_ack,
  output logic                                 o_rd_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]     o_rd_cmd_data,
  input  logic                                 i_rd_cmd_ack,
  input  logic                                 i_dma_rd_valid,
  input  logic                                 i_dma_rd_last,
  input  logic [RDATA_WIDTH-1:0]               i_dma_rd_data,
  output logic                                 o_dma_rd_ready,
  output logic [N_CH-1:0]                      o_ch_rd_valid,
  output logic [N_CH-1:0]                      o_ch_rd_last,
  output logic [RDATA_WIDTH-1:0]               o_ch_rd_data,
  input  logic [N_CH-1:0]                      i_ch_rd_ready,
  input  logic [N_CH-1:0]                      i_ch_wr_cmd_req,
  input  logic [N_CH*(DLEN_WIDTH+ADDR_WIDTH)-1:0] i_ch_wr_cmd_data,
  output logic [N_CH-1:0]                      o_ch_wr_cmd_ack,
  output logic                                 o_wr_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]     o_wr_cmd_data,
  input  logic                                 i_wr_cmd_ack,
  input  logic [N_CH-1:0]                      i_ch_wr_valid,
  input  logic [N_CH*WBYTE_WIDTH-1:0]          i_ch_wr_keep,
  input  logic [N_CH*WDATA_WIDTH-1:0]          i_ch_wr_data,
  output logic [N_CH-1:0]                      o_ch_wr_ready,
  output logic                                 o_dma_wr_valid,
  output logic [WBYTE_WIDTH-1:0]               o_dma_wr_keep,
  output logic [WDATA_WIDTH-1:0]               o_dma_wr_data,
  input  logic                                 i_dma_wr_ready,
  input  logic                                 i_wr_finish,
  output logic [N_CH-1:0]                      o_ch_wr_finish,
  output logic [N_CH-1:0]                      o_rd_grant,
  output logic [N_CH-1:0]                      o_wr_grant
);
  localparam int CMD_W = DLEN_WIDTH + ADDR_WIDTH;
  localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_DATA = 2'd2} state_t;

  function automatic logic [IW:0] rr_pick(input logic [N_CH-1:0] elig, input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = IW'((int'(ptr) + k) % N_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (int'(g) == N_CH - 1) ? '0 : g + 1'b1;
  endfunction

  state_t rd_state, rd_next, wr_state, wr_next;
  logic [IW-1:0] rd_ptr, rd_g, rd_sel, wr_ptr, wr_g, wr_sel;
  logic          rd_any, wr_any;
  logic [N_CH-1:0] rd_elig, wr_elig, rd_oh, wr_oh;
  logic [CMD_W-1:0] rd_cmd_sel, wr_cmd_sel;
  logic [WBYTE_WIDTH-1:0] wr_keep_sel;
  logic [WDATA_WIDTH-1:0] wr_data_sel;
  logic rd_end, wr_end;
  logic soft_pend, rd_soft_done, wr_soft_done, rd_apply, wr_apply;

  // A pending soft reset takes the IDLE slot of each FSM, so no grant can precede it.
  assign rd_apply = soft_pend & ~rd_soft_done & (rd_state == ST_IDLE);
  assign wr_apply = soft_pend & ~wr_soft_done & (wr_state == ST_IDLE);
  assign rd_elig  = rd_apply ? '0 : (i_ch_rd_cmd_req & i_ch_en);
  assign wr_elig  = wr_apply ? '0 : (i_ch_wr_cmd_req & i_ch_en);
  assign {rd_any, rd_sel} = rr_pick(rd_elig, rd_ptr);
  assign {wr_any, wr_sel} = rr_pick(wr_elig, wr_ptr);
  assign rd_oh  = N_CH'(1) << rd_g;
  assign wr_oh  = N_CH'(1) << wr_g;
  assign rd_end = i_dma_rd_valid & i_ch_rd_ready[rd_g] & i_dma_rd_last;
  assign wr_end = i_wr_finish;

  always_comb begin
    rd_cmd_sel  = '0;
    wr_cmd_sel  = '0;
    wr_keep_sel = '0;
    wr_data_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_sel == IW'(i)) rd_cmd_sel = i_ch_rd_cmd_data[i*CMD_W +: CMD_W];
      if (wr_sel == IW'(i)) wr_cmd_sel = i_ch_wr_cmd_data[i*CMD_W +: CMD_W];
      if (wr_g == IW'(i)) begin
        wr_keep_sel = i_ch_wr_keep[i*WBYTE_WIDTH +: WBYTE_WIDTH];
        wr_data_sel = i_ch_wr_data[i*WDATA_WIDTH +: WDATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state      <= ST_IDLE;
      wr_state      <= ST_IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      rd_g          <= '0;
      wr_g          <= '0;
      o_rd_cmd_data <= '0;
      o_wr_cmd_data <= '0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (rd_state == ST_IDLE && rd_any) begin
        rd_g          <= rd_sel;
        o_rd_cmd_data <= rd_cmd_sel;
      end
      if (wr_state == ST_IDLE && wr_any) begin
        wr_g          <= wr_sel;
        o_wr_cmd_data <= wr_cmd_sel;
      end
      if (rd_apply) rd_ptr <= '0;
      else if (rd_state == ST_DATA && rd_end) rd_ptr <= rr_next(rd_g);
      if (wr_apply) wr_ptr <= '0;
      else if (wr_state == ST_DATA && wr_end) wr_ptr <= rr_next(wr_g);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft_pend    <= 1'b0;
      rd_soft_done <= 1'b0;
      wr_soft_done <= 1'b0;
    end else if (i_soft_rst) begin
      soft_pend    <= 1'b1;
      rd_soft_done <= 1'b0;
      wr_soft_done <= 1'b0;
    end else if (soft_pend) begin
      if ((rd_soft_done | rd_apply) && (wr_soft_done | wr_apply)) begin
        soft_pend    <= 1'b0;
        rd_soft_done <= 1'b0;
        wr_soft_done <= 1'b0;
      end else begin
        if (rd_apply) rd_soft_done <= 1'b1;
        if (wr_apply) wr_soft_done <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    wr_next = wr_state;
    case (rd_state)
      ST_IDLE: if (rd_any) rd_next = ST_CMD;
      ST_CMD:  if (i_rd_cmd_ack) rd_next = ST_DATA;
      ST_DATA: if (rd_end) rd_next = ST_IDLE;
      default: rd_next = ST_IDLE;
    endcase
    case (wr_state)
      ST_IDLE: if (wr_any) wr_next = ST_CMD;
      ST_CMD:  if (i_wr_cmd_ack) wr_next = ST_DATA;
      ST_DATA: if (wr_end) wr_next = ST_IDLE;
      default: wr_next = ST_IDLE;
    endcase
  end

  // Channel-facing outputs are masked by i_ch_en; DMA-facing ones are not, so a transfer always completes.
  always_comb begin
    o_rd_cmd_req    = 1'b0;
    o_rd_grant      = '0;
    o_ch_rd_cmd_ack = '0;
    o_ch_rd_valid   = '0;
    o_ch_rd_last    = '0;
    o_ch_rd_data    = '0;
    o_dma_rd_ready  = 1'b0;
    case (rd_state)
      ST_CMD: begin
        o_rd_cmd_req = 1'b1;
        o_rd_grant   = rd_oh;
        if (i_rd_cmd_ack) o_ch_rd_cmd_ack = rd_oh & i_ch_en;
      end
      ST_DATA: begin
        o_rd_grant     = rd_oh;
        o_ch_rd_valid  = {N_CH{i_dma_rd_valid}} & rd_oh & i_ch_en;
        o_ch_rd_last   = {N_CH{i_dma_rd_last}} & rd_oh & i_ch_en;
        o_ch_rd_data   = i_dma_rd_data;
        o_dma_rd_ready = i_ch_rd_ready[rd_g];
      end
      default: ;
    endcase
  end

  always_comb begin
    o_wr_cmd_req    = 1'b0;
    o_wr_grant      = '0;
    o_ch_wr_cmd_ack = '0;
    o_ch_wr_ready   = '0;
    o_ch_wr_finish  = '0;
    o_dma_wr_valid  = 1'b0;
    o_dma_wr_keep   = '0;
    o_dma_wr_data   = '0;
    case (wr_state)
      ST_CMD: begin
        o_wr_cmd_req = 1'b1;
        o_wr_grant   = wr_oh;
        if (i_wr_cmd_ack) o_ch_wr_cmd_ack = wr_oh & i_ch_en;
      end
      ST_DATA: begin
        o_wr_grant     = wr_oh;
        o_dma_wr_valid = i_ch_wr_valid[wr_g];
        o_dma_wr_keep  = wr_keep_sel;
        o_dma_wr_data  = wr_data_sel;
        o_ch_wr_ready  = {N_CH{i_dma_wr_ready}} & wr_oh & i_ch_en;
        if (i_wr_finish) o_ch_wr_finish = wr_oh & i_ch_en;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_tlk2711_dma_arb.sv
// Self-checking bench for tlk2711_dma_arb: directed scenarios plus randomized transfers
// checked against a round-robin pointer model.
module tb_tlk2711_dma_arb;
  localparam int N  = 4;
  localparam int CW = 64;
  localparam int DW = 64;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic i_soft_rst;
  logic [N-1:0] i_ch_en, i_ch_rd_cmd_req, o_ch_rd_cmd_ack, o_ch_rd_valid, o_ch_rd_last, i_ch_rd_ready;
  logic [N*CW-1:0] i_ch_rd_cmd_data, i_ch_wr_cmd_data;
  logic o_rd_cmd_req, i_rd_cmd_ack, i_dma_rd_valid, i_dma_rd_last, o_dma_rd_ready;
  logic [CW-1:0] o_rd_cmd_data, o_wr_cmd_data;
  logic [DW-1:0] i_dma_rd_data, o_ch_rd_data, o_dma_wr_data;
  logic [N-1:0] i_ch_wr_cmd_req, o_ch_wr_cmd_ack, i_ch_wr_valid, o_ch_wr_ready, o_ch_wr_finish;
  logic o_wr_cmd_req, i_wr_cmd_ack, o_dma_wr_valid, i_dma_wr_ready, i_wr_finish;
  logic [N*KW-1:0] i_ch_wr_keep;
  logic [N*DW-1:0] i_ch_wr_data;
  logic [KW-1:0] o_dma_wr_keep;
  logic [N-1:0] o_rd_grant, o_wr_grant;

  tlk2711_dma_arb #(.N_CH(N)) dut (
    .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst), .i_ch_en(i_ch_en),
    .i_ch_rd_cmd_req(i_ch_rd_cmd_req), .i_ch_rd_cmd_data(i_ch_rd_cmd_data),
    .o_ch_rd_cmd_ack(o_ch_rd_cmd_ack), .o_rd_cmd_req(o_rd_cmd_req), .o_rd_cmd_data(o_rd_cmd_data),
    .i_rd_cmd_ack(i_rd_cmd_ack), .i_dma_rd_valid(i_dma_rd_valid), .i_dma_rd_last(i_dma_rd_last),
    .i_dma_rd_data(i_dma_rd_data), .o_dma_rd_ready(o_dma_rd_ready), .o_ch_rd_valid(o_ch_rd_valid),
    .o_ch_rd_last(o_ch_rd_last), .o_ch_rd_data(o_ch_rd_data), .i_ch_rd_ready(i_ch_rd_ready),
    .i_ch_wr_cmd_req(i_ch_wr_cmd_req), .i_ch_wr_cmd_data(i_ch_wr_cmd_data),
    .o_ch_wr_cmd_ack(o_ch_wr_cmd_ack), .o_wr_cmd_req(o_wr_cmd_req), .o_wr_cmd_data(o_wr_cmd_data),
    .i_wr_cmd_ack(i_wr_cmd_ack), .i_ch_wr_valid(i_ch_wr_valid), .i_ch_wr_keep(i_ch_wr_keep),
    .i_ch_wr_data(i_ch_wr_data), .o_ch_wr_ready(o_ch_wr_ready), .o_dma_wr_valid(o_dma_wr_valid),
    .o_dma_wr_keep(o_dma_wr_keep), .o_dma_wr_data(o_dma_wr_data), .i_dma_wr_ready(i_dma_wr_ready),
    .i_wr_finish(i_wr_finish), .o_ch_wr_finish(o_ch_wr_finish),
    .o_rd_grant(o_rd_grant), .o_wr_grant(o_wr_grant)
  );

  int checks = 0;
  int failures = 0;
  int rd_ptr_m, wr_ptr_m;
  logic [CW-1:0] rd_cmd [N];
  logic [CW-1:0] wr_cmd [N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: first requesting channel at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] elig, input int ptr);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = elig >> ((ptr + k) % N);
      if (t[0]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic drive_cmds();
    for (int i = 0; i < N; i++) begin
      i_ch_rd_cmd_data[i*CW +: CW] = rd_cmd[i];
      i_ch_wr_cmd_data[i*CW +: CW] = wr_cmd[i];
    end
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < N; i++) begin
      rd_cmd[i] = {$urandom, $urandom};
      wr_cmd[i] = {$urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_ptr_m = 0;
    wr_ptr_m = 0;
  endtask

  task automatic rd_xfer(input logic [N-1:0] mask, input int nbeats, input bit keep,
                         input int soft_beat, output int g, output int wcnt);
    logic [N-1:0] rdy;
    logic [1:0] gi;
    logic v;
    logic [DW-1:0] d;
    int b, iter;
    bit sent_soft;
    i_ch_rd_cmd_req = mask;
    drive_cmds();
    g = model_pick(mask & i_ch_en, rd_ptr_m);
    gi = 2'(g);
    wcnt = 0;
    while (o_rd_cmd_req !== 1'b1 && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    chk("rd_req_seen", o_rd_cmd_req, 1);
    chk("rd_grant", o_rd_grant, N'(1) << g);
    chk("rd_cmd_data", o_rd_cmd_data, rd_cmd[g]);
    i_rd_cmd_ack = 1'b1;
    #1 chk("rd_cmd_ack", o_ch_rd_cmd_ack, N'(1) << g);
    @(negedge clk);
    i_rd_cmd_ack = 1'b0;
    b = 0; iter = 0; sent_soft = 0;
    while (b < nbeats && iter < 2000) begin
      v = ($urandom % 4) != 0;
      rdy = N'($urandom);
      if ($urandom % 4 != 0) rdy[gi] = 1'b1;
      d = {$urandom, $urandom};
      i_dma_rd_valid = v;
      i_dma_rd_last = (b == nbeats - 1);
      i_dma_rd_data = d;
      i_ch_rd_ready = rdy;
      i_soft_rst = (b == soft_beat) && !sent_soft;
      if (i_soft_rst) sent_soft = 1;
      #1;
      chk("rd_valid_route", o_ch_rd_valid, v ? (N'(1) << g) : 0);
      chk("rd_last_route", o_ch_rd_last, (b == nbeats - 1) ? (N'(1) << g) : 0);
      chk("rd_ready_route", o_dma_rd_ready, rdy[gi]);
      chk("rd_data", o_ch_rd_data, d);
      if (v && rdy[gi]) b++;
      iter++;
      @(negedge clk);
    end
    chk("rd_beats", b, nbeats);
    i_dma_rd_valid = 0; i_dma_rd_last = 0; i_ch_rd_ready = 0; i_soft_rst = 0;
    #1 chk("rd_gap_idle", o_rd_grant, 0);
    rd_ptr_m = (g + 1) % N;
    if (soft_beat >= 0) begin
      rd_ptr_m = 0;
      wr_ptr_m = 0;
    end
    if (!keep) i_ch_rd_cmd_req = '0;
  endtask

  task automatic wr_xfer(input logic [N-1:0] mask, input int nbeats, input bit toggle, output int g);
    logic [N-1:0] vv;
    logic [1:0] gi;
    logic rdy, ph;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    int sent, iter, wcnt;
    i_ch_wr_cmd_req = mask;
    drive_cmds();
    g = model_pick(mask & i_ch_en, wr_ptr_m);
    gi = 2'(g);
    wcnt = 0;
    while (o_wr_cmd_req !== 1'b1 && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    chk("wr_req_seen", o_wr_cmd_req, 1);
    chk("wr_grant", o_wr_grant, N'(1) << g);
    chk("wr_cmd_data", o_wr_cmd_data, wr_cmd[g]);
    i_wr_cmd_ack = 1'b1;
    #1 chk("wr_cmd_ack", o_ch_wr_cmd_ack, N'(1) << g);
    @(negedge clk);
    i_wr_cmd_ack = 1'b0;
    i_ch_wr_cmd_req = '0;
    sent = 0; iter = 0; ph = 1'b1;
    while (sent < nbeats && iter < 2000) begin
      vv = N'($urandom);
      if ($urandom % 4 != 0) vv[gi] = 1'b1;
      rdy = toggle ? ph : (($urandom % 4) != 0);
      ph = ~ph;
      for (int i = 0; i < N; i++) begin
        i_ch_wr_data[i*DW +: DW] = {$urandom, $urandom};
        i_ch_wr_keep[i*KW +: KW] = KW'($urandom);
      end
      ed = {16'hC0DE, 16'(g), 32'(sent)};
      ek = KW'($urandom);
      i_ch_wr_data[g*DW +: DW] = ed;
      i_ch_wr_keep[g*KW +: KW] = ek;
      i_ch_wr_valid = vv;
      i_dma_wr_ready = rdy;
      #1;
      chk("wr_valid_route", o_dma_wr_valid, vv[gi]);
      chk("wr_data_order", o_dma_wr_data, ed);
      chk("wr_keep", o_dma_wr_keep, ek);
      chk("wr_ready_route", o_ch_wr_ready, rdy ? (N'(1) << g) : 0);
      if (vv[gi] && rdy) sent++;
      iter++;
      @(negedge clk);
    end
    chk("wr_beats", sent, nbeats);
    i_ch_wr_valid = 0; i_dma_wr_ready = 0;
    i_wr_finish = 1'b1;
    #1 chk("wr_finish", o_ch_wr_finish, N'(1) << g);
    @(negedge clk);
    i_wr_finish = 1'b0;
    #1;
    chk("wr_finish_once", o_ch_wr_finish, 0);
    chk("wr_gap_idle", o_wr_grant, 0);
    wr_ptr_m = (g + 1) % N;
  endtask

  initial begin
    int g, w;
    logic [N-1:0] m, e;
    rst = 1'b1;
    i_soft_rst = 0; i_ch_en = '1;
    i_ch_rd_cmd_req = 0; i_ch_wr_cmd_req = 0; i_rd_cmd_ack = 0; i_wr_cmd_ack = 0;
    i_dma_rd_valid = 0; i_dma_rd_last = 0; i_dma_rd_data = 0; i_ch_rd_ready = 0;
    i_ch_wr_valid = 0; i_ch_wr_keep = 0; i_ch_wr_data = 0; i_dma_wr_ready = 0; i_wr_finish = 0;
    rand_cmds();
    drive_cmds();
    repeat (2) @(negedge clk);
    chk("rst_rd_grant", o_rd_grant, 0);
    chk("rst_wr_grant", o_wr_grant, 0);
    chk("rst_rd_req", o_rd_cmd_req, 0);
    chk("rst_wr_req", o_wr_cmd_req, 0);
    chk("rst_rd_cmd_data", o_rd_cmd_data, 0);
    chk("rst_dma_wr_valid", o_dma_wr_valid, 0);
    rst = 1'b0;
    rd_ptr_m = 0; wr_ptr_m = 0;

    // single ch0 read, 32 beats
    rd_cmd[0] = {16'h0100, 48'h0000_0000_1000};
    rd_xfer(4'b0001, 32, 0, -1, g, w);
    chk("t1_grant", g, 0);
    chk("t1_cmd_const", o_rd_cmd_data, 64'h0100_0000_0000_1000);

    // two persistent requesters alternate with one idle cycle between grants
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd_xfer(4'b0011, 3, i < 3, -1, g, w);
      chk("t2_order", g, i % 2);
      if (i > 0) chk("t2_gap", w, 1);
    end

    // pointer now 2: mask 1010 grants ch3 then ch1
    rd_xfer(4'b1010, 2, 1, -1, g, w);
    chk("t3_first", g, 3);
    rd_xfer(4'b1010, 2, 0, -1, g, w);
    chk("t3_second", g, 1);

    // ch1 write, DMA ready toggling
    wr_xfer(4'b0010, 8, 1, g);
    chk("t4_grant", g, 1);

    // soft reset mid-read: transfer completes, pointer returns to ch0 after an extra idle cycle
    rd_xfer(4'b0010, 16, 0, 5, g, w);
    chk("t5_grant", g, 1);
    rd_xfer(4'b1010, 2, 0, -1, g, w);
    chk("t5_after_soft", g, 1);
    chk("t5_wait", w, 2);

    for (int it = 0; it < 12; it++) begin
      rand_cmds();
      e = N'($urandom); m = N'($urandom);
      if (m == 0) m = 4'b0001;
      if ((m & e) == 0) e = e | m;
      i_ch_en = e;
      rd_xfer(m, 1 + int'($urandom % 6), 0, -1, g, w);
      m = N'($urandom);
      if (m == 0) m = 4'b1000;
      if ((m & e) == 0) e = e | m;
      i_ch_en = e;
      wr_xfer(m, 1 + int'($urandom % 6), 0, g);
    end
    i_ch_en = '1;

    // async reset while in the command phase
    i_ch_rd_cmd_req = 4'b0100;
    w = 0;
    while (o_rd_cmd_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t6_req_seen", o_rd_cmd_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_cleared", o_rd_cmd_req, 0);
    chk("t6_grant_cleared", o_rd_grant, 0);
    chk("t6_cmd_cleared", o_rd_cmd_data, 0);
    @(negedge clk);
    i_ch_rd_cmd_req = '0;
    rst = 1'b0;
    rd_ptr_m = 0; wr_ptr_m = 0;
    rd_xfer(4'b1111, 2, 0, -1, g, w);
    chk("t6_ch0_priority", g, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
